// File: rtl/mvm_weight_loader.sv
// Streams a ROWS x COLS int8 weight matrix, row-major, into matrix write strobes.
// Optional trailing 16-bit byte-sum checksum when MVM_LOADER_CHECKSUM_EN is defined.
module mvm_weight_loader #(
    parameter int ROWS = 64,
    parameter int COLS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    s_valid,
    input  logic [7:0]              s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic                    w_en,
    output logic [$clog2(ROWS)-1:0] w_row,
    output logic [$clog2(COLS)-1:0] w_col,
    output logic [7:0]              w_data,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CSUM = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          err_q, err_d;
    logic          wen_q, wen_d;
    logic [RW-1:0] wrow_q, wrow_d;
    logic [CW-1:0] wcol_q, wcol_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          accept;
    logic          last_elem;
    logic          early;

`ifdef MVM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic [7:0]  lo_q, lo_d;
    logic        hi_q, hi_d;
`endif

    assign s_ready   = (state_q == LOAD) || (state_q == CSUM);
    assign accept    = s_valid && s_ready;
    assign last_elem = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
    assign load_busy = (state_q != IDLE);
    assign load_done = (state_q == DONE);
    assign load_err  = err_q;
    assign w_en      = wen_q;
    assign w_row     = wrow_q;
    assign w_col     = wcol_q;
    assign w_data    = wdata_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = err_q;
        wen_d   = 1'b0;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        wdata_d = wdata_q;
        early   = 1'b0;
`ifdef MVM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
`ifdef MVM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    hi_d    = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (accept) begin
                    // With a checksum trailer, s_last on any weight byte is premature.
`ifdef MVM_LOADER_CHECKSUM_EN
                    early = s_last;
`else
                    early = s_last && !last_elem;
`endif
                    if (early) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        wen_d   = 1'b1;
                        wrow_d  = row_q;
                        wcol_d  = col_q;
                        wdata_d = s_data;
`ifdef MVM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + {8'h00, s_data};
`endif
                        if (last_elem) begin
`ifdef MVM_LOADER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            if (!s_last) err_d = 1'b1;
                            state_d = DONE;
`endif
                        end else if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
`ifdef MVM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    if (!hi_q) begin
                        lo_d = s_data;
                        hi_d = 1'b1;
                        if (s_last) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        if ({s_data, lo_q} != sum_q || !s_last) err_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wdata_q <= '0;
`ifdef MVM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
            lo_q    <= '0;
            hi_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wdata_q <= wdata_d;
`ifdef MVM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_mvm_weight_loader.sv
// Scoreboard bench for mvm_weight_loader at ROWS=COLS=4; honours MVM_LOADER_CHECKSUM_EN.
module tb_mvm_weight_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       w_en;
    logic [1:0] w_row;
    logic [1:0] w_col;
    logic [7:0] w_data;
    logic       load_busy;
    logic       load_done;
    logic       load_err;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
        logic [7:0] d;
    } wr_t;

    wr_t  exp_wr[$];
    logic exp_done[$];
    wr_t  mon_e;
    logic mon_err;
    logic done_prev = 1'b0;
    int   tests = 0;
    int   fails = 0;

`ifdef MVM_LOADER_CHECKSUM_EN
    localparam int NL = -1;
`else
    localparam int NL = 15;
`endif

    mvm_weight_loader #(.ROWS(4), .COLS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .w_en       (w_en),
        .w_row      (w_row),
        .w_col      (w_col),
        .w_data     (w_data),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every write and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (w_en) begin
            tests++;
            if (exp_wr.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got (%0d,%0d,%02h) required none",
                         w_row, w_col, w_data);
            end else begin
                mon_e = exp_wr.pop_front();
                if (w_row !== mon_e.r || w_col !== mon_e.c || w_data !== mon_e.d) begin
                    fails++;
                    $display("FAIL write: got (%0d,%0d,%02h) required (%0d,%0d,%02h)",
                             w_row, w_col, w_data, mon_e.r, mon_e.c, mon_e.d);
                end
            end
        end
        if (load_done) begin
            tests++;
            if (done_prev) begin
                fails++;
                $display("FAIL done_pulse: got load_done high 2 cycles required 1");
            end else if (exp_done.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: got load_done=1 required 0");
            end else begin
                mon_err = exp_done.pop_front();
                if (load_err !== mon_err) begin
                    fails++;
                    $display("FAIL load_err: got %0b required %0b", load_err, mon_err);
                end
            end
        end
        done_prev = load_done;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_w_en", 32'(w_en), 0);
        check("rst_w_row", 32'(w_row), 0);
        check("rst_w_col", 32'(w_col), 0);
        check("rst_w_data", 32'(w_data), 0);
        check("rst_load_busy", 32'(load_busy), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_load_err", 32'(load_err), 0);
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last, input bit wr, input int idx);
        @(negedge clk); #1;
        check("s_ready_before_beat", 32'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        if (wr) exp_wr.push_back('{r: 2'(idx / 4), c: 2'(idx % 4), d: d});
        if (last) load_start = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk); #1;
        s_valid = 1'b0;
        s_data  = 8'hA5;
        s_last  = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (load_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("idle_after_load", 32'(load_busy), 0);
        check("s_ready_idle", 32'(s_ready), 0);
    endtask

    // mode 0: data = base+i; mode 1: alternating 0x80 / 0x7F.
    task automatic run_load(input int base, input int mode, input bit gap, input bit hold,
                            input int last_at, input logic [15:0] csum, input logic exp_err);
        logic [7:0] d;
        bit         last;
        bit         early;
        early = 1'b0;
        exp_done.push_back(exp_err);
        @(negedge clk); #1;
        load_start = 1'b1;
        @(negedge clk); #1;
        load_start = hold;
        check("busy_after_start", 32'(load_busy), 1);
        for (int i = 0; i < 16; i++) begin
            if (gap && i > 0) idle_cycle();
            d = (mode != 0) ? ((i % 2 != 0) ? 8'h7F : 8'h80) : 8'(base + i);
            last = (i == last_at);
`ifdef MVM_LOADER_CHECKSUM_EN
            early = last;
`else
            early = last && (i < 15);
`endif
            send_beat(d, last, !early, i);
            if (early) break;
        end
`ifdef MVM_LOADER_CHECKSUM_EN
        if (!early) begin
            send_beat(csum[7:0], 1'b0, 1'b0, 0);
            send_beat(csum[15:8], 1'b1, 1'b0, 0);
        end
`endif
        @(negedge clk); #1;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        load_start = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b1;
        s_valid    = 1'b1;
        s_data     = 8'h3C;
        s_last     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state();
        #1;
        rst        = 1'b0;
        load_start = 1'b0;
        s_valid    = 1'b0;

        // Back-to-back 0..15
`ifdef MVM_LOADER_CHECKSUM_EN
        run_load(0, 0, 1'b0, 1'b0, -1, 16'h0078, 1'b0);
        run_load(0, 0, 1'b0, 1'b0, -1, 16'h0079, 1'b1);
`else
        run_load(0, 0, 1'b0, 1'b0, 15, 16'h0000, 1'b0);
        // Final beat without s_last: error but all 16 writes land
        run_load(0, 0, 1'b0, 1'b0, -1, 16'h0000, 1'b1);
`endif

        // Gapped s_valid
        run_load(16, 0, 1'b1, 1'b0, NL, 16'h0178, 1'b0);

        // Premature s_last on beat index 5
        run_load(0, 0, 1'b0, 1'b0, 5, 16'h0000, 1'b1);

        // Reset mid-load after byte 7, with start and a beat colliding with rst
        @(negedge clk); #1;
        load_start = 1'b1;
        @(negedge clk); #1;
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'(i), 1'b0, 1'b1, i);
        @(negedge clk); #1;
        rst        = 1'b1;
        load_start = 1'b1;
        s_valid    = 1'b1;
        s_data     = 8'h08;
        s_last     = 1'b0;
        @(negedge clk);
        check_reset_state();
        #1;
        rst        = 1'b0;
        load_start = 1'b0;
        s_valid    = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(load_busy), 0);
        run_load(64, 0, 1'b0, 1'b0, NL, 16'h0478, 1'b0);

        // load_start held throughout, extreme signed values
        run_load(0, 1, 1'b0, 1'b1, NL, 16'h07F8, 1'b0);

        repeat (3) @(negedge clk);
        check("writes_outstanding", 32'(exp_wr.size()), 0);
        check("dones_outstanding", 32'(exp_done.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mvm_weight_loader.md
MVM_WEIGHT_LOADER -- requirements
Module: mvm_weight_loader

Interface
REQ-001 SHALL have parameter ROWS, default 64, matrix row count.
REQ-002 SHALL have parameter COLS, default 64, matrix column count.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load_start  input  1  begins one full matrix load; honoured only in IDLE.
REQ-006 SHALL have port s_valid  input  1  stream byte valid.
REQ-007 SHALL have port s_data  input  8  signed int8 weight, row-major (row 0 col 0 first).
REQ-008 SHALL have port s_last  input  1  marks final stream beat.
REQ-009 SHALL have port s_ready  output  1  loader accepts a beat.
REQ-010 SHALL have port w_en  output  1  matrix write strobe.
REQ-011 SHALL have port w_row  output  $clog2(ROWS)  write row index.
REQ-012 SHALL have port w_col  output  $clog2(COLS)  write column index.
REQ-013 SHALL have port w_data  output  8  signed weight to write.
REQ-014 SHALL have port load_busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port load_done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port load_err  output  1  framing/checksum error flag, valid with load_done.

Function
REQ-017 SHALL implement states IDLE, LOAD, CSUM, DONE.
REQ-018 SHALL move IDLE->LOAD on load_start, clearing row/col counters and load_err.
REQ-019 SHALL drive s_ready high only in LOAD and CSUM; beat accepted when s_valid && s_ready.
REQ-020 SHALL, per accepted LOAD beat, drive w_en=1, w_row/w_col = counter values, w_data=s_data, one cycle after acceptance (latency 1, registered).
REQ-021 SHALL hold w_en=0 on every cycle following no accepted LOAD beat; s_valid gaps stall counters.
REQ-022 SHALL increment col per beat; at col=COLS-1 wrap col to 0 and increment row.
REQ-023 SHALL, on acceptance of element (ROWS-1, COLS-1), go to CSUM if checksum enabled, else DONE.
REQ-024 SHALL, if s_last is accepted before the final beat, set load_err, drop that beat's write (w_en stays 0), and go to DONE.
REQ-025 SHALL, if the final beat arrives without s_last, set load_err but complete normally.
REQ-026 SHALL, in DONE, pulse load_done for exactly one cycle then return to IDLE.
REQ-027 SHALL ignore load_start in any state other than IDLE.
REQ-028 SHALL never issue more than ROWS*COLS writes per load.

Reset
REQ-029 SHALL, on rst, force IDLE, counters 0, s_ready=0, w_en=0, w_row=0, w_col=0, w_data=0, load_busy=0, load_done=0, load_err=0.
REQ-030 SHALL, on rst mid-load, abort with no further writes from the next cycle; already-written weights are not cleared.
REQ-031 SHALL give rst priority over load_start and any stream beat in the same cycle.

Configuration
REQ-032 SHALL compile checksum logic only when macro MVM_LOADER_CHECKSUM_EN is defined.
REQ-033 SHALL, with MVM_LOADER_CHECKSUM_EN, accumulate the unsigned sum of all weight bytes modulo 2^16, then in CSUM accept two bytes (low then high), set load_err on mismatch, and expect s_last on the high byte.
REQ-034 SHALL, without MVM_LOADER_CHECKSUM_EN, never enter CSUM; s_last expected on element (ROWS-1, COLS-1).

Verification
REQ-035 SHALL cover: ROWS=COLS=4, load_start, 16 back-to-back bytes 0..15, s_last on byte 15 -> 16 writes (r,c)=(i/4,i%4), w_data=i, one cycle late; load_done pulse; load_err=0.
REQ-036 SHALL cover: s_valid toggled every other cycle -> writes only after accepted beats, indices contiguous, no duplicates.
REQ-037 SHALL cover: s_last on byte 5 of 16 -> 5 writes, load_err=1 with load_done, return to IDLE.
REQ-038 SHALL cover: rst asserted after byte 7 -> w_en=0 next cycle, all outputs reset values, new load_start restarts at (0,0).
REQ-039 SHALL cover, MVM_LOADER_CHECKSUM_EN: bytes 0..15 then 0x78,0x00 -> load_err=0; then 0x79,0x00 -> load_err=1.
REQ-040 SHALL cover: load_start held during LOAD and values 0x80/0x7F -> ignored restart, w_data passes -128/127 unchanged.
